// File: rtl/i2s_playback_tx.sv
// i2s_playback_tx: I2S DAC transmitter fed by a stereo-pair FIFO; bclk/lrclk come from an
// external clock domain and are oversampled by clk (at least 4x bclk).
module i2s_playback_tx #(
   parameter int DATA_W     = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        bclk,
   input  logic                        lrclk,
   input  logic                        enable,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [DATA_W-1:0]           s_left,
   input  logic [DATA_W-1:0]           s_right,
   output logic                        dacdat,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        underflow,
   input  logic                        clear_underflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] BITS = CW'(DATA_W);
   localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

   logic              bclk_s1, bclk_s2, bclk_h, lr_s1, lr_s2, lr_h;
   logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [DATA_W-1:0] shift, held_r;
   logic [CW-1:0]     bit_cnt;
   logic              fall, chan_edge, left_edge, right_edge, empty, push, pop, uf_set;

   // lr_h holds lrclk as sampled at the previous bclk fall
   assign fall       = bclk_h & ~bclk_s2;
   assign chan_edge  = fall & enable & (lr_s2 != lr_h);
   assign left_edge  = chan_edge & ~lr_s2;
   assign right_edge = chan_edge & lr_s2;
   assign empty      = fifo_level == '0;
   assign s_ready    = fifo_level != FULL;
   assign push       = s_valid & s_ready;
   assign pop        = left_edge & ~empty;
   assign uf_set     = left_edge & empty;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         bclk_s1 <= 1'b0;
         bclk_s2 <= 1'b0;
         bclk_h  <= 1'b0;
         lr_s1   <= 1'b0;
         lr_s2   <= 1'b0;
         lr_h    <= 1'b0;
      end else begin
         bclk_s1 <= bclk;
         bclk_s2 <= bclk_s1;
         bclk_h  <= bclk_s2;
         lr_s1   <= lrclk;
         lr_s2   <= lr_s1;
         if (fall) lr_h <= lr_s2;
      end

   always_ff @(posedge clk)
      if (push) begin
         mem_l[wr_ptr] <= s_left;
         mem_r[wr_ptr] <= s_right;
      end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         underflow  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push != pop) fifo_level <= push ? fifo_level + LW'(1) : fifo_level - LW'(1);
         underflow <= uf_set | (underflow & ~clear_underflow);
      end

   // A starved frame sends zeros on both channels; a disabled transmitter idles saturated
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         shift   <= '0;
         held_r  <= '0;
         bit_cnt <= BITS;
         dacdat  <= 1'b0;
      end else if (!enable) begin
         held_r  <= '0;
         bit_cnt <= BITS;
         dacdat  <= 1'b0;
      end else if (fall) begin
         if (left_edge) begin
            shift   <= empty ? '0 : mem_l[rd_ptr];
            held_r  <= empty ? '0 : mem_r[rd_ptr];
            bit_cnt <= '0;
         end else if (right_edge) begin
            shift   <= held_r;
            bit_cnt <= '0;
         end else if (bit_cnt < BITS) begin
            dacdat  <= shift[DATA_W-1];
            shift   <= {shift[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + CW'(1);
         end else begin
            dacdat  <= 1'b0;
         end
      end
endmodule

// File: tb/tb_i2s_playback_tx.sv
// tb_i2s_playback_tx: directed I2S playback scenarios checked every cycle against a
// word/bit-index model of the frame, plus literal word checks decoded from dacdat.
module tb_i2s_playback_tx;
   localparam int DW = 24;
   localparam int DEPTH = 4;

   typedef struct packed {logic [DW-1:0] l; logic [DW-1:0] r;} pair_t;

   logic          clk = 0, reset_n = 0, bclk = 1, lrclk = 1, enable = 0;
   logic          s_valid = 0, clear_underflow = 0;
   logic [DW-1:0] s_left = '0, s_right = '0;
   logic          s_ready, dacdat, underflow;
   logic [2:0]    fifo_level;

   i2s_playback_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .bclk(bclk), .lrclk(lrclk), .enable(enable),
      .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
      .dacdat(dacdat), .fifo_level(fifo_level), .underflow(underflow),
      .clear_underflow(clear_underflow)
   );

   always #10 clk = ~clk;

   int vectors = 0, errs = 0;
   int fall_cnt = 0;
   logic fall_lr = 0;
   bit cap[$];

   pair_t         q[$];
   logic [DW-1:0] m_word = '0, m_held = '0;
   int            m_k = DW;
   logic          m_dac = 0, m_prev = 0, m_uf = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_at(input int s, input int n);
      logic [31:0] w = '0;
      for (int i = 0; i < n; i++) w = {w[30:0], logic'(cap[s+i])};
      return w;
   endfunction

   // Channel edge loads a word; the k-th following fall sends bit DW-1-k, then zeros
   task automatic model_fall(input logic lr, input logic en, output logic set);
      set = 0;
      if (en) begin
         if (lr != m_prev) begin
            if (!lr) begin
               if (q.size() == 0) begin
                  m_word = '0;
                  m_held = '0;
                  set = 1;
               end else begin
                  m_word = q[0].l;
                  m_held = q[0].r;
                  void'(q.pop_front());
               end
            end else m_word = m_held;
            m_k = 0;
         end else if (m_k < DW) begin
            m_dac = m_word[DW-1-m_k];
            m_k++;
         end else m_dac = 0;
      end
      m_prev = lr;
   endtask

   always begin
      logic c_sv, c_en, c_clr, rdy, set;
      logic [DW-1:0] c_l, c_r;
      @(posedge clk);
      c_sv = s_valid; c_l = s_left; c_r = s_right; c_en = enable; c_clr = clear_underflow;
      #1;
      if (!reset_n) begin
         q.delete();
         m_word = '0; m_held = '0; m_k = DW; m_dac = 0; m_prev = 0; m_uf = 0;
         fall_cnt = 0;
      end else begin
         rdy = q.size() != DEPTH;
         set = 0;
         if (fall_cnt > 0) begin
            fall_cnt--;
            if (fall_cnt == 0) begin
               model_fall(fall_lr, c_en, set);
               cap.push_back(dacdat);
            end
         end
         if (!c_en) begin
            m_dac = 0; m_k = DW; m_held = '0;
         end
         if (c_sv && rdy) q.push_back({c_l, c_r});
         m_uf = set | (m_uf & ~c_clr);
      end
      chk("dacdat", dacdat, m_dac);
      chk("fifo_level", fifo_level, q.size());
      chk("s_ready", s_ready, q.size() != DEPTH);
      chk("underflow", underflow, m_uf);
   end

   task automatic bit_clk(input logic lr, input logic psh, input logic clr);
      @(negedge clk);
      bclk = 0; lrclk = lr; fall_cnt = 3; fall_lr = lr;
      @(negedge clk);
      @(negedge clk);
      if (psh) s_valid = 1;
      if (clr) clear_underflow = 1;
      @(negedge clk);
      s_valid = 0; clear_underflow = 0;
      repeat (4) @(negedge clk);
      bclk = 1;
      repeat (8) @(negedge clk);
   endtask

   task automatic frame(input int nl, input int nr);
      for (int i = 0; i < nl; i++) bit_clk(0, 0, 0);
      for (int i = 0; i < nr; i++) bit_clk(1, 0, 0);
   endtask

   task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
      @(negedge clk);
      s_left = l; s_right = r; s_valid = 1;
      @(negedge clk);
      s_valid = 0;
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clear_underflow = 1;
      @(negedge clk);
      clear_underflow = 0;
   endtask

   initial begin
      repeat (5) @(negedge clk);
      reset_n = 1;
      repeat (4) @(negedge clk);
      chk("rst_dacdat", dacdat, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", s_ready, 1);
      chk("rst_uf", underflow, 0);
      bit_clk(1, 0, 0);
      bit_clk(1, 0, 0);

      push(24'hA5A5A5, 24'h5A5A5A);
      push(24'h123456, 24'h654321);
      push(24'hFEDCBA, 24'h0ABCDE);
      push(24'h800001, 24'h7FFFFE);
      chk("full_level", fifo_level, 4);
      chk("full_ready", s_ready, 0);
      push(24'h111111, 24'h222222);
      chk("full_5th_ignored", fifo_level, 4);

      enable = 1;
      cap.delete();
      frame(32, 32);
      chk("f1_left", word_at(1, 24), 32'hA5A5A5);
      chk("f1_lpad", word_at(25, 7), 0);
      chk("f1_right", word_at(33, 24), 32'h5A5A5A);
      chk("f1_rpad", word_at(57, 7), 0);
      chk("pop_level", fifo_level, 3);
      chk("pop_ready", s_ready, 1);

      cap.delete();
      frame(32, 32);
      chk("f2_left", word_at(1, 24), 32'h123456);
      chk("f2_right", word_at(33, 24), 32'h654321);
      chk("f2_level", fifo_level, 2);

      s_left = 24'hC0FFEE; s_right = 24'h0BEEF0;
      cap.delete();
      bit_clk(0, 1, 0);
      chk("pushpop_level", fifo_level, 2);
      for (int i = 0; i < 31; i++) bit_clk(0, 0, 0);
      for (int i = 0; i < 32; i++) bit_clk(1, 0, 0);
      chk("f3_left", word_at(1, 24), 32'hFEDCBA);
      chk("f3_right", word_at(33, 24), 32'h0ABCDE);
      cap.delete();
      frame(32, 32);
      chk("f4_left", word_at(1, 24), 32'h800001);
      cap.delete();
      frame(32, 32);
      chk("f5_order_left", word_at(1, 24), 32'hC0FFEE);
      chk("f5_order_right", word_at(33, 24), 32'h0BEEF0);
      chk("f5_level", fifo_level, 0);

      cap.delete();
      frame(32, 32);
      chk("uf_set", underflow, 1);
      chk("uf_zero_l", word_at(0, 32), 0);
      chk("uf_zero_r", word_at(32, 32), 0);
      clr_pulse();
      chk("uf_clear", underflow, 0);
      bit_clk(0, 0, 1);
      for (int i = 0; i < 31; i++) bit_clk(0, 0, 0);
      for (int i = 0; i < 32; i++) bit_clk(1, 0, 0);
      chk("uf_set_wins", underflow, 1);
      clr_pulse();
      chk("uf_clear2", underflow, 0);

      push(24'hABCDEF, 24'h13579B);
      push(24'h2468AC, 24'hFDB975);
      cap.delete();
      frame(20, 32);
      chk("short_left", word_at(1, 19), 32'h55E6F);
      chk("short_next", word_at(21, 24), 32'h13579B);
      cap.delete();
      frame(20, 20);
      chk("short2_left", word_at(1, 19), 32'h12345);
      chk("short2_right", word_at(21, 19), 32'h7EDCB);

      push(24'h0F0F0F, 24'hF0F0F0);
      enable = 0;
      frame(32, 0);
      chk("dis_no_pop", fifo_level, 1);
      enable = 1;
      cap.delete();
      frame(0, 32);
      chk("en_right_zero", word_at(0, 32), 0);
      cap.delete();
      frame(32, 32);
      chk("en_left", word_at(1, 24), 32'h0F0F0F);
      chk("en_right", word_at(33, 24), 32'hF0F0F0);

      push(24'hFFF000, 24'h000FFF);
      frame(11, 0);
      chk("mid_dac_high", dacdat, 1);
      @(negedge clk);
      reset_n = 0;
      #1;
      chk("mid_rst_dac", dacdat, 0);
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_ready", s_ready, 1);
      repeat (3) @(negedge clk);
      reset_n = 1;
      repeat (4) @(negedge clk);
      push(24'hA1B2C3, 24'hD4E5F6);
      cap.delete();
      frame(21, 32);
      chk("post_rst_zero_l", word_at(0, 21), 0);
      chk("post_rst_zero_r", word_at(21, 32), 0);
      cap.delete();
      frame(32, 32);
      chk("post_rst_left", word_at(1, 24), 32'hA1B2C3);
      chk("post_rst_right", word_at(33, 24), 32'hD4E5F6);

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/i2s_playback_tx.md
I2S_PLAYBACK_TX -- requirements
Module: i2s_playback_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning the sample width per channel (16..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of stereo-pair entries; it is a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single interface clock; every flop in the block is clocked by it.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active low.
REQ-005 SHALL have port bclk, input, 1 bit: the bit clock from the audio clock generator or the external master, asynchronous to clk.
REQ-006 SHALL have port lrclk, input, 1 bit: the playback word clock, asynchronous to clk; 0 = left channel, 1 = right channel.
REQ-007 SHALL have port enable, input, 1 bit: transmitter enable.
REQ-008 SHALL have ports s_valid (input, 1), s_ready (output, 1), s_left (input, DATA_W) and s_right (input, DATA_W): the sample-pair push handshake.
REQ-009 SHALL have port dacdat, output, 1 bit: the serial DAC data.
REQ-010 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: the current FIFO occupancy.
REQ-011 SHALL have port underflow, output, 1 bit: sticky underflow flag.
REQ-012 SHALL have port clear_underflow, input, 1 bit: a synchronous clear for underflow.

Function
REQ-013 SHALL pass bclk and lrclk each through a 2-flop synchronizer, then one history flop; a bclk falling edge is the synchronized value at 0 while the history flop holds 1.
REQ-014 SHALL operate with clk of at least 4x bclk; below that, behaviour is undefined.
REQ-015 SHALL update dacdat only on a detected bclk fall, registered, exactly 3 clk cycles after the bclk pin falls.
REQ-016 SHALL, on each detected fall, compare the synchronized lrclk with the lrclk value held from the previous fall; any difference is a channel edge.
REQ-017 SHALL, at a channel edge, load the shift register with the word for the new channel (left when lrclk=0), clear the bit counter, and leave dacdat unchanged on that fall.
REQ-018 SHALL, on each subsequent fall while bit counter < DATA_W, drive dacdat <= shift MSB, shift left by 1 and increment the bit counter; this places the MSB one bclk after the lrclk transition (I2S format).
REQ-019 SHALL, once bit counter = DATA_W, drive dacdat = 0 until the next channel edge; the counter saturates and does not wrap.
REQ-020 SHALL pop one FIFO entry at each left-channel edge (lrclk 1->0), taking s_left as the left word and holding s_right for the following right edge.
REQ-021 SHALL, at a right-channel edge, load the held right word without popping.
REQ-022 SHALL, if the FIFO is empty at a left-channel edge, transmit all-zero words on both channels of that frame and set underflow.
REQ-023 SHALL, if a channel edge arrives before DATA_W bits are sent, truncate the word and start the new word immediately.
REQ-024 SHALL define s_ready = (fifo_level != FIFO_DEPTH); a push happens when s_valid & s_ready on a rising clk.
REQ-025 SHALL, on a push and pop in the same cycle, apply both; fifo_level is unchanged.
REQ-026 SHALL provide no empty-FIFO bypass: a push and pop in the same cycle on an empty FIFO counts as an underflow, and the pushed entry remains stored.
REQ-027 SHALL use pointers that wrap modulo FIFO_DEPTH, with full/empty derived from fifo_level.
REQ-028 SHALL, while enable=0, perform no pops, hold dacdat=0, hold the bit counter saturated and suppress underflow; pushes are still accepted.
REQ-029 SHALL, after enable goes 0->1, begin transmission only at the next left-channel edge; right edges before that transmit zeros.
REQ-030 SHALL give set priority on underflow: a set and clear_underflow in the same cycle leaves underflow=1.

Reset
REQ-031 SHALL, on reset_n low, asynchronously clear the synchronizers, history flops, shift register, held right word, bit counter (saturated state), pointers and fifo_level, and set dacdat=0 and underflow=0.
REQ-032 SHALL drive s_ready=1 after reset.
REQ-033 SHALL, on reset asserted mid-word, drop the output to dacdat=0 immediately; after release, output restarts at the next left-channel edge.

Verification
REQ-034 SHALL cover normal playback: DATA_W=24, clk 50 MHz, bclk 3.072 MHz, lrclk 48 kHz, push L=0xA5A5A5, R=0x5A5A5A, enable=1 -> on dacdat, from the 2nd bclk fall after the lrclk fall, 24 bits MSB first of 0xA5A5A5, then 8 zero bits, then 0x5A5A5A after lrclk rises; dacdat transitions 3 clk after bclk fall.
REQ-035 SHALL cover FIFO full: push 4 pairs with no bclk -> fifo_level=4, s_ready=0; the 5th push is ignored; after one left edge, fifo_level=3 and s_ready=1.
REQ-036 SHALL cover underflow: empty FIFO, enable=1, run one frame -> dacdat all 0 and underflow=1; pulse clear_underflow with no edge -> underflow=0; clear coinciding with a new underflow -> underflow stays 1.
REQ-037 SHALL cover a short frame: lrclk period of 32 bclk with DATA_W=24 versus a 20-bclk channel -> in the 20-bclk case only the top 19 bits are sent and the next word starts cleanly.
REQ-038 SHALL cover simultaneous push/pop: fifo_level=2, push on the same cycle as a left-edge pop -> fifo_level stays 2 and data order is preserved.
REQ-039 SHALL cover reset mid-word: assert reset_n=0 after 10 bits -> dacdat=0, fifo_level=0, s_ready=1; after release, the first data appears only after the next lrclk 1->0.
